// File: rtl/sel_pipe_reg.sv
// Purpose: registered N-way channel selector with a two-entry skid buffer for datapath pipeline boundaries.
// Latency: one cycle from accept to out_valid; one transfer per cycle while out_ready stays high.
// Backpressure: absorbs one extra entry into the skid register, then drops in_ready until a consume frees it.
module sel_pipe_reg #(
   parameter  int W  = 32,
   parameter  int N  = 4,
   localparam int SW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N*W-1:0] in_data,
   input  logic [SW-1:0]  in_sel,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic           flush,
   output logic [W-1:0]   out_data,
   output logic [SW-1:0]  out_sel,
   output logic           out_err,
   output logic           out_valid,
   input  logic           out_ready
);

   // State encoding is {main_valid, skid_valid}; 2'b01 is never produced.
   typedef enum logic [1:0] {
      S_EMPTY = 2'b00,
      S_ONE   = 2'b10,
      S_TWO   = 2'b11
   } state_t;

   state_t          r_state;
   logic [W-1:0]    r_main_dat;
   logic [SW-1:0]   r_main_sel;
   logic            r_main_err;
   logic [W-1:0]    r_skid_dat;
   logic [SW-1:0]   r_skid_sel;
   logic            r_skid_err;

   logic [W-1:0]    w_sel_dat;
   logic            w_sel_err;
   logic            w_accept;
   logic            w_consume;

   // Handshake signals decode straight from state bits, so out_ready never reaches in_ready.
   assign in_ready  = ~r_state[0];
   assign out_valid = r_state[1];
   assign out_data  = r_main_dat;
   assign out_sel   = r_main_sel;
   assign out_err   = r_main_err;

   assign w_accept  = in_valid & ~r_state[0];
   assign w_consume = r_state[1] & out_ready;

   // Pick the addressed channel; an out-of-range index matches nothing and yields zero.
   always_comb begin
      w_sel_dat = '0;
      for (int k = 0; k < N; k++) begin
         if (in_sel == SW'(k)) begin
            w_sel_dat = in_data[k*W +: W];
         end
      end
   end

   // When N fills the select space every index is legal, so the error flag is tied off.
   generate
      if (N == (1 << SW)) begin : g_err_pow2
         assign w_sel_err = 1'b0;
      end else begin : g_err_range
         assign w_sel_err = (in_sel >= SW'(N));
      end
   endgenerate

   // Occupancy and entry storage; flush empties the stage but leaves payload registers untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_EMPTY;
         r_main_dat <= '0;
         r_main_sel <= '0;
         r_main_err <= 1'b0;
         r_skid_dat <= '0;
         r_skid_sel <= '0;
         r_skid_err <= 1'b0;
      end else if (flush) begin
         r_state <= S_EMPTY;
      end else begin
         case (r_state)
            S_EMPTY: begin
               if (w_accept) begin
                  r_main_dat <= w_sel_dat;
                  r_main_sel <= in_sel;
                  r_main_err <= w_sel_err;
                  r_state    <= S_ONE;
               end
            end
            S_ONE: begin
               if (w_accept && w_consume) begin
                  r_main_dat <= w_sel_dat;
                  r_main_sel <= in_sel;
                  r_main_err <= w_sel_err;
               end else if (w_accept) begin
                  // Downstream stalled: park the newer entry behind main.
                  r_skid_dat <= w_sel_dat;
                  r_skid_sel <= in_sel;
                  r_skid_err <= w_sel_err;
                  r_state    <= S_TWO;
               end else if (w_consume) begin
                  r_state <= S_EMPTY;
               end
            end
            S_TWO: begin
               if (w_consume) begin
                  r_main_dat <= r_skid_dat;
                  r_main_sel <= r_skid_sel;
                  r_main_err <= r_skid_err;
                  r_state    <= S_ONE;
               end
            end
            default: begin
               r_state <= S_EMPTY;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sel_pipe_reg.sv
// Bench for sel_pipe_reg: table of per-cycle handshake vectors with a payload scoreboard,
// plus hand sequences for async reset in TWO and the out-of-range path with N=3.
// Outputs are sampled 1 ns after the falling edge, well away from the rising edge.
module tb_sel_pipe_reg;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // N=4 instance
   logic [4*W-1:0] in_data;
   logic [1:0]     in_sel;
   logic           in_valid, in_ready, flush;
   logic [W-1:0]   out_data;
   logic [1:0]     out_sel;
   logic           out_err, out_valid, out_ready;

   // N=3 instance
   logic [3*W-1:0] d3_in_data;
   logic [1:0]     d3_in_sel;
   logic           d3_in_valid, d3_in_ready, d3_flush;
   logic [W-1:0]   d3_out_data;
   logic [1:0]     d3_out_sel;
   logic           d3_out_err, d3_out_valid, d3_out_ready;

   sel_pipe_reg #(.W(W), .N(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
      .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
      .out_data(out_data), .out_sel(out_sel), .out_err(out_err),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   sel_pipe_reg #(.W(W), .N(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .in_data(d3_in_data), .in_sel(d3_in_sel),
      .in_valid(d3_in_valid), .in_ready(d3_in_ready), .flush(d3_flush),
      .out_data(d3_out_data), .out_sel(d3_out_sel), .out_err(d3_out_err),
      .out_valid(d3_out_valid), .out_ready(d3_out_ready)
   );

   typedef struct packed {
      logic [W-1:0] dat;
      logic [1:0]   sel;
      logic         err;
   } exp_t;

   typedef struct {
      logic       v;
      logic [1:0] s;
      logic       r;
      logic       f;
      logic       e_rdy;
      logic       e_ov;
   } vec_t;

   exp_t sb[$];
   vec_t vq[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic exp_t model(input logic [4*W-1:0] d, input logic [1:0] s, input int n);
      exp_t e;
      e.sel = s;
      if (int'(s) < n) begin
         e.dat = d[int'(s)*W +: W];
         e.err = 1'b0;
      end else begin
         e.dat = '0;
         e.err = 1'b1;
      end
      return e;
   endfunction

   task automatic add(input int v, input int s, input int r, input int f, input int e_rdy, input int e_ov);
      vq.push_back('{v[0], 2'(s), r[0], f[0], e_rdy[0], e_ov[0]});
   endtask

   // One cycle: drive at falling edge, check handshake and payload, update scoreboard.
   task automatic cyc(input logic v, input logic [1:0] s, input logic r, input logic f,
                      input logic e_rdy, input logic e_ov, input logic [15:0] tag);
      exp_t got;
      @(negedge clk);
      for (int k = 0; k < 4; k++) in_data[k*W +: W] = {16'hAAAA + 16'(k) * 16'h1111, tag};
      in_valid  = v;
      in_sel    = s;
      out_ready = r;
      flush     = f;
      #1;
      check("in_ready", 64'(in_ready), 64'(e_rdy));
      check("out_valid", 64'(out_valid), 64'(e_ov));
      if (out_valid) begin
         got = {out_data, out_sel, out_err};
         if (sb.size() == 0) check("spurious_out_valid", 64'(out_valid), 64'(0));
         else check("out_entry", 64'(got), 64'(sb[0]));
      end
      if (f) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
         if (v && in_ready) sb.push_back(model(in_data, in_sel, 4));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      in_data = '0; in_sel = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      d3_in_data = '0; d3_in_sel = '0; d3_in_valid = 1'b0; d3_flush = 1'b0; d3_out_ready = 1'b0;

      // Vector table: v, sel, out_ready, flush, expected in_ready, expected out_valid
      // streaming sel 0..3, no bubbles
      add(1,0,1,0, 1,0); add(1,1,1,0, 1,1); add(1,2,1,0, 1,1); add(1,3,1,0, 1,1);
      add(0,0,1,0, 1,1); add(0,0,1,0, 1,0);
      // skid: stall with offers sel 1,2,3, then release
      add(1,1,0,0, 1,0); add(1,2,0,0, 1,1); add(1,3,0,0, 0,1); add(1,3,0,0, 0,1);
      add(1,3,1,0, 0,1); add(1,3,1,0, 1,1); add(0,0,1,0, 1,1); add(0,0,0,0, 1,0);
      // flush in TWO with in_valid high
      add(1,0,0,0, 1,0); add(1,1,0,0, 1,1); add(1,2,0,1, 0,1); add(1,3,1,0, 1,0);
      add(0,0,1,0, 1,1); add(0,0,1,0, 1,0);
      // flush in ONE with accept and consume in the same cycle
      add(1,2,1,0, 1,0); add(1,0,1,1, 1,1); add(0,0,1,0, 1,0);
      // hold in ONE while stalled
      add(1,1,0,0, 1,0); add(0,0,0,0, 1,1); add(0,0,0,0, 1,1); add(0,0,1,0, 1,1);
      add(0,0,0,0, 1,0);

      // Reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid_low", 64'(out_valid), 64'(0));
      rst_n = 1'b1;
      #1;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_data", 64'(out_data), 64'(0));
      check("rst_out_sel", 64'(out_sel), 64'(0));
      check("rst_out_err", 64'(out_err), 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(1));

      for (int i = 0; i < vq.size(); i++) begin
         cyc(vq[i].v, vq[i].s, vq[i].r, vq[i].f, vq[i].e_rdy, vq[i].e_ov, 16'(i));
      end

      // Async reset while in TWO
      cyc(1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0100);
      cyc(1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0101);
      @(negedge clk);
      #2;
      check("two_before_reset_in_ready", 64'(in_ready), 64'(0));
      rst_n = 1'b0;
      #1;
      check("async_rst_out_valid", 64'(out_valid), 64'(0));
      check("async_rst_in_ready", 64'(in_ready), 64'(1));
      check("async_rst_out_data", 64'(out_data), 64'(0));
      check("async_rst_out_sel", 64'(out_sel), 64'(0));
      sb.delete();
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1'b1, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0200);
      cyc(1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0201);
      cyc(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0202);

      // Out-of-range index with N=3
      @(negedge clk);
      for (int k = 0; k < 3; k++) d3_in_data[k*W +: W] = 32'h3000_0000 + 32'(k);
      d3_in_sel    = 2'd3;
      d3_in_valid  = 1'b1;
      d3_out_ready = 1'b1;
      #1;
      check("n3_in_ready", 64'(d3_in_ready), 64'(1));
      @(negedge clk);
      #1;
      check("n3_oor_valid", 64'(d3_out_valid), 64'(1));
      check("n3_oor_data", 64'(d3_out_data), 64'(0));
      check("n3_oor_err", 64'(d3_out_err), 64'(1));
      check("n3_oor_sel", 64'(d3_out_sel), 64'(3));
      d3_in_sel = 2'd2;
      @(negedge clk);
      #1;
      check("n3_ch2_valid", 64'(d3_out_valid), 64'(1));
      check("n3_ch2_data", 64'(d3_out_data), 64'(32'h3000_0002));
      check("n3_ch2_err", 64'(d3_out_err), 64'(0));
      check("n3_ch2_sel", 64'(d3_out_sel), 64'(2));
      d3_in_valid = 1'b0;
      @(negedge clk);
      #1;
      check("n3_drain_valid", 64'(d3_out_valid), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
